accel_desc_queue: RTL and testbench

ACCEL_DESC_QUEUE -- requirements
Module: accel_desc_queue

---
 rtl/accel_desc_pkg.sv | 17 +
 rtl/accel_desc_fifo.sv | 58 +++++
 rtl/accel_desc_queue.sv | 127 ++++++++++++
 tb/tb_accel_desc_queue.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_desc_pkg.sv
// Shared constants and helpers for the accelerator descriptor queue.
// A descriptor is stored as one word {addr, len}, with len in the low bits.
package accel_desc_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned LEN_WIDTH_DEF  = 14;

    function automatic int unsigned desc_width(input int unsigned addr_w, input int unsigned len_w);
        return addr_w + len_w;
    endfunction

    // Count must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/accel_desc_fifo.sv
// Per-accelerator descriptor FIFO with registered storage and a synchronous flush.
// Flush wins over a same-cycle push or pop.
module accel_desc_fifo
    import accel_desc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 30,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_push = i_push && !w_full && !i_flush;
    assign w_pop  = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/accel_desc_queue.sv
// Per-accelerator descriptor queues feeding a shared read DMA through a round-robin
// issuer; each accelerator holds at most one descriptor in flight.
module accel_desc_queue
    import accel_desc_pkg::*;
#(
    parameter int unsigned ACCEL_COUNT = 4,
    parameter int unsigned DEST_WIDTH  = $clog2(ACCEL_COUNT),
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int unsigned DEPTH       = 4,
    localparam int unsigned OCC_W      = occ_width(DEPTH),
    localparam int unsigned DESC_W     = desc_width(ADDR_WIDTH, LEN_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_desc_valid,
    input  logic [DEST_WIDTH-1:0]        s_desc_accel,
    input  logic [ADDR_WIDTH-1:0]        s_desc_addr,
    input  logic [LEN_WIDTH-1:0]         s_desc_len,
    output logic [ACCEL_COUNT-1:0]       s_desc_ready,
    output logic                         m_desc_valid,
    output logic [DEST_WIDTH-1:0]        m_desc_accel,
    output logic [ADDR_WIDTH-1:0]        m_desc_addr,
    output logic [LEN_WIDTH-1:0]         m_desc_len,
    input  logic [ACCEL_COUNT-1:0]       accel_busy,
    input  logic [ACCEL_COUNT-1:0]       accel_done,
    input  logic [ACCEL_COUNT-1:0]       accel_flush,
    output logic [ACCEL_COUNT*OCC_W-1:0] occupancy,
    output logic [ACCEL_COUNT-1:0]       inflight,
    output logic                         error,
    input  logic                         error_ack
);

    logic [DESC_W-1:0]      w_head [ACCEL_COUNT];
    logic [OCC_W-1:0]       w_count [ACCEL_COUNT];
    logic [ACCEL_COUNT-1:0] w_push;
    logic [ACCEL_COUNT-1:0] w_pop;
    logic [ACCEL_COUNT-1:0] w_full;
    logic [ACCEL_COUNT-1:0] w_eligible;
    logic                   w_grant_vld;
    logic [DEST_WIDTH-1:0]  w_grant_idx;
    logic [DEST_WIDTH-1:0]  w_rr_next;
    int unsigned            w_scan;
    logic                   w_hit;
    logic                   w_full_drop;
    logic                   w_overflow;
    logic [DEST_WIDTH-1:0]  r_rr_ptr;
    logic [ACCEL_COUNT-1:0] r_inflight;
    logic                   r_error;

    for (genvar gi = 0; gi < ACCEL_COUNT; gi++) begin : g_queue
        assign w_push[gi] = s_desc_valid && (s_desc_accel == DEST_WIDTH'(gi))
                            && !w_full[gi] && !accel_flush[gi];
        assign w_pop[gi]  = w_grant_vld && (w_grant_idx == DEST_WIDTH'(gi));
        assign w_eligible[gi] = (w_count[gi] != '0) && !r_inflight[gi]
                                && !accel_busy[gi] && !accel_flush[gi];
        assign occupancy[gi*OCC_W +: OCC_W] = w_count[gi];

        accel_desc_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (DESC_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[gi]),
            .i_pop   (w_pop[gi]),
            .i_flush (accel_flush[gi]),
            .i_data  ({s_desc_addr, s_desc_len}),
            .o_head  (w_head[gi]),
            .o_count (w_count[gi]),
            .o_full  (w_full[gi])
        );
    end

    // A push dropped only because its queue is being flushed is not an error.
    always_comb begin
        w_hit       = 1'b0;
        w_full_drop = 1'b0;
        for (int unsigned i = 0; i < ACCEL_COUNT; i++) begin
            if (s_desc_accel == DEST_WIDTH'(i)) begin
                w_hit = 1'b1;
                if (w_full[i] && !accel_flush[i]) w_full_drop = 1'b1;
            end
        end
        w_overflow = s_desc_valid && (!w_hit || w_full_drop);
    end

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = 0;
        for (int unsigned k = 0; k < ACCEL_COUNT; k++) begin
            w_scan = (32'(r_rr_ptr) + k) % ACCEL_COUNT;
            if (!w_grant_vld && w_eligible[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = DEST_WIDTH'(w_scan);
            end
        end
        w_rr_next = (32'(w_grant_idx) == ACCEL_COUNT - 1) ? '0 : w_grant_idx + DEST_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_desc_valid <= 1'b0;
            m_desc_accel <= '0;
            m_desc_addr  <= '0;
            m_desc_len   <= '0;
            r_rr_ptr     <= '0;
            r_inflight   <= '0;
            r_error      <= 1'b0;
        end else begin
            m_desc_valid <= w_grant_vld;
            if (w_grant_vld) begin
                m_desc_accel              <= w_grant_idx;
                {m_desc_addr, m_desc_len} <= w_head[w_grant_idx];
                r_rr_ptr                  <= w_rr_next;
            end
            r_inflight <= ((r_inflight & ~accel_done) | w_pop) & ~accel_flush;
            r_error    <= (r_error & ~error_ack) | w_overflow;
        end
    end

    assign s_desc_ready = ~w_full;
    assign inflight     = r_inflight;
    assign error        = r_error;

endmodule

// File: tb/tb_accel_desc_queue.sv
// Self-checking bench for accel_desc_queue: per-accelerator scoreboards filled on push,
// drained and compared by a monitor on every issued descriptor.
module tb_accel_desc_queue;

    localparam int NA = 4;
    localparam int DW = 2;
    localparam int AW = 16;
    localparam int LW = 14;
    localparam int OW = 3;

    logic          clk;
    logic          rst_n;
    logic          s_desc_valid;
    logic [DW-1:0] s_desc_accel;
    logic [AW-1:0] s_desc_addr;
    logic [LW-1:0] s_desc_len;
    logic [NA-1:0] s_desc_ready;
    logic          m_desc_valid;
    logic [DW-1:0] m_desc_accel;
    logic [AW-1:0] m_desc_addr;
    logic [LW-1:0] m_desc_len;
    logic [NA-1:0] accel_busy;
    logic [NA-1:0] accel_done;
    logic [NA-1:0] accel_flush;
    logic [NA*OW-1:0] occupancy;
    logic [NA-1:0] inflight;
    logic          error;
    logic          error_ack;

    accel_desc_queue #(
        .ACCEL_COUNT (NA),
        .DEST_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .DEPTH       (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_desc_valid (s_desc_valid),
        .s_desc_accel (s_desc_accel),
        .s_desc_addr  (s_desc_addr),
        .s_desc_len   (s_desc_len),
        .s_desc_ready (s_desc_ready),
        .m_desc_valid (m_desc_valid),
        .m_desc_accel (m_desc_accel),
        .m_desc_addr  (m_desc_addr),
        .m_desc_len   (m_desc_len),
        .accel_busy   (accel_busy),
        .accel_done   (accel_done),
        .accel_flush  (accel_flush),
        .occupancy    (occupancy),
        .inflight     (inflight),
        .error        (error),
        .error_ack    (error_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int order_log[$];
    int issue_cyc[$];
    logic [AW+LW-1:0] sb [NA][$];
    logic [AW+LW-1:0] mon_exp;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && m_desc_valid) begin
            checks++;
            if (sb[m_desc_accel].size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected accel=%0d addr=%h len=%0d required=none",
                         m_desc_accel, m_desc_addr, m_desc_len);
            end else begin
                mon_exp = sb[m_desc_accel].pop_front();
                if ({m_desc_addr, m_desc_len} !== mon_exp) begin
                    failures++;
                    $display("FAIL issue_payload accel=%0d got=%h required=%h",
                             m_desc_accel, {m_desc_addr, m_desc_len}, mon_exp);
                end
            end
            order_log.push_back(int'(m_desc_accel));
            issue_cyc.push_back(cyc);
            issue_cnt++;
        end
    end

    function automatic logic [OW-1:0] occ(input int a);
        return occupancy[a*OW +: OW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        s_desc_valid = 1'b0;
        accel_busy = '0;
        accel_done = '0;
        accel_flush = '0;
        error_ack = 1'b0;
        for (int i = 0; i < NA; i++) sb[i].delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input int a, input logic [AW-1:0] ad, input logic [LW-1:0] ln,
                        input bit accepted);
        s_desc_valid = 1'b1;
        s_desc_accel = DW'(a);
        s_desc_addr  = ad;
        s_desc_len   = ln;
        if (accepted) sb[a].push_back({ad, ln});
        tick();
        s_desc_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [NA-1:0] mask);
        accel_done = mask;
        tick();
        accel_done = '0;
    endtask

    task automatic wait_count(input int target, input string name);
        int budget = 20;
        while (issue_cnt < target && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (issue_cnt < target) begin
            failures++;
            $display("FAIL %s_timeout issues=%0d required=%0d", name, issue_cnt, target);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 8;
        if (m_desc_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", m_desc_valid); end
        if (m_desc_accel !== '0) begin failures++; $display("FAIL rst_accel got=%0d required=0", m_desc_accel); end
        if (m_desc_addr !== '0) begin failures++; $display("FAIL rst_addr got=%h required=0", m_desc_addr); end
        if (m_desc_len !== '0) begin failures++; $display("FAIL rst_len got=%0d required=0", m_desc_len); end
        if (occupancy !== '0) begin failures++; $display("FAIL rst_occ got=%h required=0", occupancy); end
        if (inflight !== '0) begin failures++; $display("FAIL rst_inflight got=%b required=0", inflight); end
        if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b required=0", error); end
        if (s_desc_ready !== 4'hF) begin failures++; $display("FAIL rst_ready got=%b required=1111", s_desc_ready); end
    endtask

    task automatic test_single_issue();
        int base = issue_cnt;
        push(2, 16'h0100, 14'd64, 1'b1);
        checks += 2;
        if (m_desc_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b required=0", m_desc_valid); end
        if (occ(2) !== 3'd1) begin failures++; $display("FAIL single_occ got=%0d required=1", occ(2)); end
        tick();
        checks += 6;
        if (m_desc_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b required=1", m_desc_valid); end
        if (m_desc_accel !== 2'd2) begin failures++; $display("FAIL single_accel got=%0d required=2", m_desc_accel); end
        if (m_desc_addr !== 16'h0100) begin failures++; $display("FAIL single_addr got=%h required=0100", m_desc_addr); end
        if (m_desc_len !== 14'd64) begin failures++; $display("FAIL single_len got=%0d required=64", m_desc_len); end
        if (inflight[2] !== 1'b1) begin failures++; $display("FAIL single_inflight got=%b required=1", inflight[2]); end
        if (occ(2) !== 3'd0) begin failures++; $display("FAIL single_pop got=%0d required=0", occ(2)); end
        tick();
        checks += 3;
        if (m_desc_valid !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b required=0", m_desc_valid); end
        if (m_desc_addr !== 16'h0100) begin failures++; $display("FAIL single_hold got=%h required=0100", m_desc_addr); end
        if (issue_cnt !== base + 1) begin failures++; $display("FAIL single_count got=%0d required=%0d", issue_cnt, base + 1); end
        pulse_done(4'b0100);
        pulse_done(4'b0100);
        checks++;
        if (inflight !== '0) begin failures++; $display("FAIL single_done got=%b required=0000", inflight); end
    endtask

    task automatic test_overflow();
        int base = issue_cnt;
        accel_busy[1] = 1'b1;
        for (int i = 0; i < 4; i++) push(1, AW'(16'h1000 + i * 16), LW'(10 + i), 1'b1);
        checks += 3;
        if (occ(1) !== 3'd4) begin failures++; $display("FAIL ovf_occ got=%0d required=4", occ(1)); end
        if (s_desc_ready[1] !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b required=0", s_desc_ready[1]); end
        if (error !== 1'b0) begin failures++; $display("FAIL ovf_early_err got=%b required=0", error); end
        push(1, 16'h1FFF, 14'd99, 1'b0);
        checks += 2;
        if (error !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b required=1", error); end
        if (occ(1) !== 3'd4) begin failures++; $display("FAIL ovf_occ_keep got=%0d required=4", occ(1)); end
        error_ack = 1'b1;
        tick();
        error_ack = 1'b0;
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL ovf_ack got=%b required=0", error); end
        push(1, 16'h1EEE, 14'd98, 1'b0);
        error_ack = 1'b1;
        push(1, 16'h1DDD, 14'd97, 1'b0);
        error_ack = 1'b0;
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL ovf_ack_race got=%b required=1", error); end
        error_ack = 1'b1;
        tick();
        error_ack = 1'b0;
        accel_busy[1] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wait_count(base + i, "ovf_drain");
            pulse_done(4'b0010);
        end
        checks++;
        if (sb[1].size() != 0) begin failures++; $display("FAIL ovf_left got=%0d required=0", sb[1].size()); end
    endtask

    task automatic test_round_robin();
        int base;
        apply_reset();
        base = issue_cnt;
        order_log.delete();
        issue_cyc.delete();
        for (int a = 0; a < NA; a++) push(a, AW'(16'h2000 + a * 256), LW'(100 + a), 1'b1);
        wait_count(base + 4, "rr_first");
        checks++;
        if (order_log.size() != 4) begin
            failures++;
            $display("FAIL rr_size got=%0d required=4", order_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order_log[i] != i) begin failures++; $display("FAIL rr_order idx=%0d got=%0d required=%0d", i, order_log[i], i); end
                if (i > 0) begin
                    checks++;
                    if (issue_cyc[i] - issue_cyc[i-1] != 1) begin
                        failures++;
                        $display("FAIL rr_gap idx=%0d got=%0d required=1", i, issue_cyc[i] - issue_cyc[i-1]);
                    end
                end
            end
        end
        pulse_done(4'b0110);
        push(3, 16'h2333, 14'd33, 1'b1);
        push(0, 16'h2000, 14'd30, 1'b1);
        repeat (5) tick();
        checks++;
        if (issue_cnt != base + 4) begin failures++; $display("FAIL rr_blocked got=%0d required=%0d", issue_cnt, base + 4); end
        pulse_done(4'b0001);
        wait_count(base + 5, "rr_after_done0");
        checks++;
        if (order_log[$] != 0) begin failures++; $display("FAIL rr_second got=%0d required=0", order_log[$]); end
        pulse_done(4'b1000);
        wait_count(base + 6, "rr_after_done3");
        checks++;
        if (order_log[$] != 3) begin failures++; $display("FAIL rr_third got=%0d required=3", order_log[$]); end
        pulse_done(4'b1001);
    endtask

    task automatic test_inflight_gate();
        int base = issue_cnt;
        push(0, 16'h3000, 14'd1, 1'b1);
        push(0, 16'h3010, 14'd2, 1'b1);
        wait_count(base + 1, "inf_first");
        accel_busy[0] = 1'b1;
        repeat (6) tick();
        checks += 3;
        if (issue_cnt != base + 1) begin failures++; $display("FAIL inf_hold got=%0d required=%0d", issue_cnt, base + 1); end
        if (inflight[0] !== 1'b1) begin failures++; $display("FAIL inf_set got=%b required=1", inflight[0]); end
        if (occ(0) !== 3'd1) begin failures++; $display("FAIL inf_occ got=%0d required=1", occ(0)); end
        pulse_done(4'b0001);
        repeat (3) tick();
        checks += 2;
        if (issue_cnt != base + 1) begin failures++; $display("FAIL inf_busy got=%0d required=%0d", issue_cnt, base + 1); end
        if (inflight[0] !== 1'b0) begin failures++; $display("FAIL inf_clear got=%b required=0", inflight[0]); end
        accel_busy[0] = 1'b0;
        wait_count(base + 2, "inf_second");
        pulse_done(4'b0001);
    endtask

    task automatic test_back_to_back();
        int base = issue_cnt;
        accel_busy[0] = 1'b1;
        push(0, 16'h4000, 14'd11, 1'b1);
        push(0, 16'h4100, 14'd12, 1'b1);
        accel_busy[0] = 1'b0;
        push(0, 16'h4200, 14'd13, 1'b1);
        checks += 2;
        if (occ(0) !== 3'd2) begin failures++; $display("FAIL b2b_occ got=%0d required=2", occ(0)); end
        if (m_desc_valid !== 1'b1) begin failures++; $display("FAIL b2b_issue got=%b required=1", m_desc_valid); end
        for (int i = 1; i <= 3; i++) begin
            wait_count(base + i, "b2b_drain");
            pulse_done(4'b0001);
        end
        checks++;
        if (sb[0].size() != 0) begin failures++; $display("FAIL b2b_left got=%0d required=0", sb[0].size()); end
    endtask

    task automatic test_flush();
        int base = issue_cnt;
        push(3, 16'h5000, 14'd50, 1'b1);
        wait_count(base + 1, "fl_first");
        accel_busy[3] = 1'b1;
        accel_busy[1] = 1'b1;
        for (int i = 0; i < 3; i++) push(3, AW'(16'h5100 + i), LW'(51 + i), 1'b1);
        push(1, 16'h5800, 14'd80, 1'b1);
        push(1, 16'h5900, 14'd81, 1'b1);
        checks += 2;
        if (occ(3) !== 3'd3) begin failures++; $display("FAIL fl_pre_occ got=%0d required=3", occ(3)); end
        if (inflight[3] !== 1'b1) begin failures++; $display("FAIL fl_pre_inf got=%b required=1", inflight[3]); end
        accel_flush[3] = 1'b1;
        push(3, 16'h5FFF, 14'd59, 1'b0);
        accel_flush[3] = 1'b0;
        sb[3].delete();
        checks += 4;
        if (occ(3) !== 3'd0) begin failures++; $display("FAIL fl_occ got=%0d required=0", occ(3)); end
        if (inflight[3] !== 1'b0) begin failures++; $display("FAIL fl_inf got=%b required=0", inflight[3]); end
        if (error !== 1'b0) begin failures++; $display("FAIL fl_err got=%b required=0", error); end
        if (occ(1) !== 3'd2) begin failures++; $display("FAIL fl_other got=%0d required=2", occ(1)); end
        accel_busy[3] = 1'b0;
        repeat (5) tick();
        checks++;
        if (issue_cnt != base + 1) begin failures++; $display("FAIL fl_quiet got=%0d required=%0d", issue_cnt, base + 1); end
        accel_busy[1] = 1'b0;
        for (int i = 2; i <= 3; i++) begin
            wait_count(base + i, "fl_drain");
            pulse_done(4'b0010);
        end
        checks++;
        if (sb[1].size() != 0) begin failures++; $display("FAIL fl_left got=%0d required=0", sb[1].size()); end
    endtask

    task automatic test_reset_mid();
        int base = issue_cnt;
        push(2, 16'h6200, 14'd62, 1'b1);
        wait_count(base + 1, "rm_first");
        accel_busy[1] = 1'b1;
        for (int i = 0; i < 4; i++) push(1, AW'(16'h6100 + i), LW'(61 + i), 1'b1);
        push(1, 16'h61FF, 14'd7, 1'b0);
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (m_desc_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b required=0", m_desc_valid); end
        if (m_desc_accel !== '0) begin failures++; $display("FAIL rm_accel got=%0d required=0", m_desc_accel); end
        if (m_desc_addr !== '0) begin failures++; $display("FAIL rm_addr got=%h required=0", m_desc_addr); end
        if (m_desc_len !== '0) begin failures++; $display("FAIL rm_len got=%0d required=0", m_desc_len); end
        if (occupancy !== '0) begin failures++; $display("FAIL rm_occ got=%h required=0", occupancy); end
        if (inflight !== '0) begin failures++; $display("FAIL rm_inf got=%b required=0", inflight); end
        if (error !== 1'b0) begin failures++; $display("FAIL rm_err got=%b required=0", error); end
        for (int i = 0; i < NA; i++) sb[i].delete();
        accel_busy = '0;
        tick();
        tick();
        rst_n = 1'b1;
        base = issue_cnt;
        repeat (20) tick();
        checks += 2;
        if (issue_cnt != base) begin failures++; $display("FAIL rm_quiet got=%0d required=%0d", issue_cnt, base); end
        if (s_desc_ready !== 4'hF) begin failures++; $display("FAIL rm_ready got=%b required=1111", s_desc_ready); end
    endtask

    initial begin
        rst_n = 1'b0;
        s_desc_valid = 1'b0;
        s_desc_accel = '0;
        s_desc_addr = '0;
        s_desc_len = '0;
        accel_busy = '0;
        accel_done = '0;
        accel_flush = '0;
        error_ack = 1'b0;
        test_reset();
        test_single_issue();
        test_overflow();
        test_round_robin();
        test_inflight_gate();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
